pc_sequencer: RTL
=================

PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 Parameter WIDTH, default 32, address width in bits.
REQ-002 Parameter RESET_PC, default 32'h0000_3000, first fetch address after reset.
REQ-003 Parameter EXC_VECTOR, default 32'h0000_4180, exception entry address.
REQ-004 Parameter IMEM_BASE, default 32'h0000_3000, and IMEM_SIZE, default 32'h0000_1000 (bytes): legal fetch window.
REQ-005 clk  input  1  single clock, all state updates on rising edge.
REQ-006 reset_n  input  1  synchronous active-low reset.
REQ-007 stall_i  input  1  hold PC (fetch/decode frozen).
REQ-008 br_take_i / br_target_i  input  1 / WIDTH  taken branch from decode and its target.
REQ-009 jal_take_i / jal_target_i  input  1 / WIDTH  jal/j redirect and target.
REQ-010 jr_take_i / jr_target_i  input  1 / WIDTH  jr/jalr redirect and target.
REQ-011 exc_req_i  input  1  exception/interrupt taken this cycle.
REQ-012 eret_req_i / epc_i  input  1 / WIDTH  eret request and return address.
REQ-013 pc_o  output  WIDTH  current fetch address (registered).
REQ-014 pc_plus4_o  output  WIDTH  pc_o + 4, modulo 2^WIDTH.
REQ-015 pend_o  output  1  a redirect captured during stall is waiting.
REQ-016 adel_o  output  1  current pc_o misaligned or outside fetch window.

Function
REQ-017 Next-PC priority, highest first: exc_req_i -> EXC_VECTOR; eret_req_i -> epc_i; pending redirect; jr_take_i -> jr_target_i; jal_take_i -> jal_target_i; br_take_i -> br_target_i; else pc_o + 4.
REQ-018 Latency: a selected redirect appears on pc_o one cycle after the request is sampled.
REQ-019 exc_req_i and eret_req_i act regardless of stall_i; either clears the pending register in the same edge.
REQ-020 With stall_i=1 and no exc/eret: pc_o holds; if any of jr/jal/br take is high, the highest-priority target is written to the pending register and pend set (last write wins while stalled).
REQ-021 With stall_i=0 and pend=1: pc_o loads the pending target, pend clears; concurrent jr/jal/br inputs in that cycle are ignored.
REQ-022 With stall_i=0 and pend=0: pc_o loads the REQ-017 selection directly; pend stays 0.
REQ-023 Simultaneous exc_req_i and eret_req_i: exception wins.
REQ-024 pc_o + 4 wraps to 0 at 2^WIDTH - 4 with no flag.
REQ-025 adel_o = (pc_o[1:0] != 0) or pc_o < IMEM_BASE or pc_o >= IMEM_BASE + IMEM_SIZE; purely a function of registered pc_o; sequencer does not self-redirect on adel_o.
REQ-026 Targets are accepted unmodified (misaligned targets load and raise adel_o).

Reset
REQ-027 When reset_n=0 at a rising edge: pc_o <= RESET_PC, pending target <= 0, pend_o <= 0; reset overrides all other inputs including exc_req_i.
REQ-028 Reset asserted mid-stall with pend=1 discards the pending redirect.
REQ-029 After reset, with defaults, adel_o = 0 and pc_plus4_o = 32'h0000_3004.

Structure
REQ-030 RESET_PC, EXC_VECTOR, IMEM_BASE, IMEM_SIZE defaults and a next-PC source-select enum (EXC, ERET, PEND, JR, JAL, BR, SEQ) live in the shared CPU package.
REQ-031 One sub-module, pc_prio_sel: combinational priority encoder producing the select enum and target; PC and pending registers stay in pc_sequencer.

Verification
REQ-032 Reset, then 3 free cycles -> pc_o = 3000, 3004, 3008, 300C; pend_o = 0, adel_o = 0.
REQ-033 At pc_o=3010, br_take_i=1 target 3040 and jr_take_i=1 target 3100 same cycle -> next pc_o = 3100.
REQ-034 stall_i=1 for 2 cycles with jal_take_i target 3200 in first stall cycle -> pc_o holds, pend_o=1; stall drops -> next pc_o = 3200, pend_o = 0.
REQ-035 stall_i=1, pend=1 (target 3200), exc_req_i=1 -> next pc_o = 4180, pend_o = 0; then eret_req_i with epc_i=3020 -> pc_o = 3020.
REQ-036 jr_target_i = 3002 -> pc_o = 3002, adel_o = 1; jr_target_i = 5000 -> adel_o = 1.
REQ-037 reset_n=0 during stall with pend=1 -> pc_o = 3000, pend_o = 0 next edge.

Source files
------------

// File: rtl/pc_sequencer_pkg.sv
// pc_sequencer_pkg: shared CPU constants and next-PC source encoding
package pc_sequencer_pkg;

    localparam logic [31:0] DEF_RESET_PC   = 32'h0000_3000;
    localparam logic [31:0] DEF_EXC_VECTOR = 32'h0000_4180;
    localparam logic [31:0] DEF_IMEM_BASE  = 32'h0000_3000;
    localparam logic [31:0] DEF_IMEM_SIZE  = 32'h0000_1000;

    typedef enum logic [2:0] {
        SRC_EXC,
        SRC_ERET,
        SRC_PEND,
        SRC_JR,
        SRC_JAL,
        SRC_BR,
        SRC_SEQ
    } next_src_e;

endpackage

// File: rtl/pc_sequencer_prio_sel.sv
// pc_prio_sel: fixed-priority next-PC source select and target mux
module pc_prio_sel
    import pc_sequencer_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter logic [WIDTH-1:0] EXC_VECTOR = WIDTH'(DEF_EXC_VECTOR)
) (
    input  logic             exc_req_i,
    input  logic             eret_req_i,
    input  logic             pend_i,
    input  logic             jr_take_i,
    input  logic             jal_take_i,
    input  logic             br_take_i,
    input  logic [WIDTH-1:0] epc_i,
    input  logic [WIDTH-1:0] pend_target_i,
    input  logic [WIDTH-1:0] jr_target_i,
    input  logic [WIDTH-1:0] jal_target_i,
    input  logic [WIDTH-1:0] br_target_i,
    input  logic [WIDTH-1:0] seq_pc_i,
    output next_src_e        sel_o,
    output logic [WIDTH-1:0] target_o
);

    // Highest-priority active source wins; sequential fetch is the fallback
    always_comb begin
        sel_o = exc_req_i  ? SRC_EXC  :
                eret_req_i ? SRC_ERET :
                pend_i     ? SRC_PEND :
                jr_take_i  ? SRC_JR   :
                jal_take_i ? SRC_JAL  :
                br_take_i  ? SRC_BR   : SRC_SEQ;
        target_o = exc_req_i  ? EXC_VECTOR    :
                   eret_req_i ? epc_i         :
                   pend_i     ? pend_target_i :
                   jr_take_i  ? jr_target_i   :
                   jal_take_i ? jal_target_i  :
                   br_take_i  ? br_target_i   : seq_pc_i;
    end

endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer: fetch PC register with redirect priority and stall-time pending capture
module pc_sequencer
    import pc_sequencer_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter logic [WIDTH-1:0] RESET_PC   = WIDTH'(DEF_RESET_PC),
    parameter logic [WIDTH-1:0] EXC_VECTOR = WIDTH'(DEF_EXC_VECTOR),
    parameter logic [WIDTH-1:0] IMEM_BASE  = WIDTH'(DEF_IMEM_BASE),
    parameter logic [WIDTH-1:0] IMEM_SIZE  = WIDTH'(DEF_IMEM_SIZE)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             stall_i,
    input  logic             br_take_i,
    input  logic [WIDTH-1:0] br_target_i,
    input  logic             jal_take_i,
    input  logic [WIDTH-1:0] jal_target_i,
    input  logic             jr_take_i,
    input  logic [WIDTH-1:0] jr_target_i,
    input  logic             exc_req_i,
    input  logic             eret_req_i,
    input  logic [WIDTH-1:0] epc_i,
    output logic [WIDTH-1:0] pc_o,
    output logic [WIDTH-1:0] pc_plus4_o,
    output logic             pend_o,
    output logic             adel_o
);

    localparam logic [WIDTH:0] IMEM_END = {1'b0, IMEM_BASE} + {1'b0, IMEM_SIZE};

    logic [WIDTH-1:0] pc_q, pc_d;
    logic [WIDTH-1:0] pend_tgt_q, pend_tgt_d;
    logic             pend_q, pend_d;
    logic [WIDTH-1:0] tgt;
    next_src_e        sel;

    assign pc_plus4_o = pc_q + WIDTH'(4);

    // The pending redirect is only eligible once the stall has dropped, so a
    // stalled cycle falls through to jr/jal/br and overwrites the pending slot.
    pc_prio_sel #(
        .WIDTH      (WIDTH),
        .EXC_VECTOR (EXC_VECTOR)
    ) u_prio_sel (
        .exc_req_i     (exc_req_i),
        .eret_req_i    (eret_req_i),
        .pend_i        (pend_q & ~stall_i),
        .jr_take_i     (jr_take_i),
        .jal_take_i    (jal_take_i),
        .br_take_i     (br_take_i),
        .epc_i         (epc_i),
        .pend_target_i (pend_tgt_q),
        .jr_target_i   (jr_target_i),
        .jal_target_i  (jal_target_i),
        .br_target_i   (br_target_i),
        .seq_pc_i      (pc_plus4_o),
        .sel_o         (sel),
        .target_o      (tgt)
    );

    // Exception/eret always load and flush; a stall holds PC and parks redirects
    always_comb begin
        pc_d       = pc_q;
        pend_d     = pend_q;
        pend_tgt_d = pend_tgt_q;
        if (sel == SRC_EXC || sel == SRC_ERET) begin
            pc_d       = tgt;
            pend_d     = 1'b0;
            pend_tgt_d = '0;
        end else if (stall_i) begin
            if (sel != SRC_SEQ) begin
                pend_d     = 1'b1;
                pend_tgt_d = tgt;
            end
        end else begin
            pc_d   = tgt;
            pend_d = 1'b0;
        end
    end

    // State registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            pc_q       <= RESET_PC;
            pend_q     <= 1'b0;
            pend_tgt_q <= '0;
        end else begin
            pc_q       <= pc_d;
            pend_q     <= pend_d;
            pend_tgt_q <= pend_tgt_d;
        end
    end

    assign pc_o   = pc_q;
    assign pend_o = pend_q;
    assign adel_o = (pc_q[1:0] != 2'b00) || (pc_q < IMEM_BASE) || ({1'b0, pc_q} >= IMEM_END);

endmodule
